// File: rtl/conv_bias_relu.sv
// conv_bias_relu: post-accumulation stage of the conv layer.
// Walks output channels 0..OC, requests each channel's bias from the bias
// loader, then turns NPIX accumulator sums per channel into int8 results:
// (acc >>> SHIFT) + bias, ReLU, saturate to 127.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               one-cycle pulse starting a full layer pass
//   busy, done          pass in progress / one-cycle end-of-pass pulse
//   c_load, cout        bias request pulse and current output channel
//   bias                signed int8 bias for cout, valid from the cycle after c_load
//   acc_valid/ready/data upstream accumulator stream (ready is combinational)
//   out_valid/ready     downstream handshake
//   out_data, out_ch    int8 result (0..127) and its channel index
module conv_bias_relu #(
    parameter int unsigned OC    = 7,
    parameter int unsigned NPIX  = 676,
    parameter int unsigned ACC_W = 20,
    parameter int unsigned SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             c_load,
    output logic [3:0]       cout,
    input  logic [7:0]       bias,
    input  logic             acc_valid,
    output logic             acc_ready,
    input  logic [ACC_W-1:0] acc_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [3:0]       out_ch
);

    localparam int unsigned PIX_W = $clog2(NPIX + 1);
    localparam int unsigned CH_W  = 4;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CH_W-1:0]  cout_nxt;
    logic [PIX_W-1:0] pix_cnt, pix_nxt;
    logic             take;

    // Rescale, bias add at ACC_W+1 bits (cannot overflow), ReLU, saturate
    logic signed [ACC_W-1:0] acc_shr;
    logic signed [ACC_W:0]   sum;
    logic [7:0]              res;

    assign acc_shr = $signed(acc_data) >>> SHIFT;
    assign sum     = {acc_shr[ACC_W-1], acc_shr} + {{(ACC_W - 7){bias[7]}}, bias};

    always_comb begin
        res = sum[7:0];
        if (sum[ACC_W]) begin
            res = 8'd0;
        end else if (|sum[ACC_W-1:7]) begin
            res = 8'd127;
        end
    end

    // Next-state, counters and upstream ready
    always_comb begin
        state_nxt = state;
        cout_nxt  = cout;
        pix_nxt   = pix_cnt;
        acc_ready = 1'b0;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    cout_nxt  = '0;
                    pix_nxt   = '0;
                end
            end
            LOAD: begin
                state_nxt = RUN;
            end
            RUN: begin
                // Output slot free (or freeing this cycle) and channel not yet complete
                acc_ready = (!out_valid || out_ready) && (pix_cnt < PIX_W'(NPIX));
                take      = acc_valid && acc_ready;
                if (take) begin
                    pix_nxt = pix_cnt + PIX_W'(1);
                    if (pix_cnt == PIX_W'(NPIX - 1)) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Wait for the channel's last result to leave before moving on
                if (!out_valid || out_ready) begin
                    if (cout == CH_W'(OC)) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = LOAD;
                        cout_nxt  = cout + CH_W'(1);
                        pix_nxt   = '0;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cout_nxt  = '0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and control outputs registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cout    <= '0;
            pix_cnt <= '0;
            busy    <= 1'b0;
            c_load  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cout    <= cout_nxt;
            pix_cnt <= pix_nxt;
            busy    <= (state_nxt != IDLE);
            c_load  <= (state_nxt == LOAD);
            done    <= (state_nxt == DONE);
        end
    end

    // Output register: a new result overwrites a departing one without a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= res;
            out_ch    <= cout;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_bias_relu.sv
// Directed bench for conv_bias_relu with a reduced layer (2 channels x 4 pixels).
module tb_conv_bias_relu;

    localparam int unsigned OC    = 1;
    localparam int unsigned NPIX  = 4;
    localparam int unsigned ACC_W = 20;
    localparam int unsigned SHIFT = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic             c_load;
    logic [3:0]       cout;
    logic [7:0]       bias;
    logic             acc_valid;
    logic             acc_ready;
    logic [ACC_W-1:0] acc_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [3:0]       out_ch;

    conv_bias_relu #(
        .OC(OC), .NPIX(NPIX), .ACC_W(ACC_W), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .c_load(c_load), .cout(cout), .bias(bias),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Event log sampled mid-cycle
    int         cyc = 0;
    int         n_cload = 0;
    int         n_done = 0;
    int         done_cyc = 0;
    int         last_hs = 0;
    logic [3:0] cl_q[$];
    logic [3:0] oq_ch[$];
    logic [7:0] oq_data[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (c_load) begin
            n_cload <= n_cload + 1;
            cl_q.push_back(cout);
        end
        if (out_valid && out_ready) begin
            oq_ch.push_back(out_ch);
            oq_data.push_back(out_data);
            last_hs <= cyc;
        end
        if (done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    // Present one sample, wait for acceptance, check the registered result
    task automatic send(input string tag, input int v, input int exp_d, input int exp_ch);
        int n;
        acc_data  = ACC_W'(v);
        acc_valid = 1'b1;
        #1;
        n = 0;
        while (!acc_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) chk({tag, "_timeout"}, 32'd0, 32'd1);
        tick();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk(tag, 32'(out_data), 32'(exp_d));
        chk({tag, "_ch"}, 32'(out_ch), 32'(exp_ch));
        acc_valid = 1'b0;
    endtask

    int base_o;
    int base_c;
    int base_d;
    int model;
    int n;
    logic tk;

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        bias      = 8'd3;
        acc_valid = 1'b0;
        acc_data  = '0;
        out_ready = 1'b1;
        tick();
        tick();

        // Reset values
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cload", 32'(c_load), 0);
        chk("rst_accrdy", 32'(acc_ready), 0);
        chk("rst_oval", 32'(out_valid), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_och", 32'(out_ch), 0);
        chk("rst_odata", 32'(out_data), 0);
        rst = 1'b1;
        tick();

        // 1: full pass with constant input and no backpressure
        base_o    = oq_data.size();
        base_c    = cl_q.size();
        base_d    = n_done;
        acc_data  = ACC_W'(80);
        acc_valid = 1'b1;
        pulse_start();
        chk("t1_busy", 32'(busy), 1);
        chk("t1_cload", 32'(c_load), 1);
        wait_done("t1");
        tick();
        tick();
        chk("t1_busy_after", 32'(busy), 0);
        chk("t1_ncload", 32'(cl_q.size() - base_c), 2);
        chk("t1_cload0", 32'(cl_q[base_c]), 0);
        chk("t1_cload1", 32'(cl_q[base_c + 1]), 1);
        chk("t1_nout", 32'(oq_data.size() - base_o), 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t1_och%0d", k), 32'(oq_ch[base_o + k]), 32'(k / 4));
            chk($sformatf("t1_odata%0d", k), 32'(oq_data[base_o + k]), 8);
        end
        chk("t1_ndone", 32'(n_done - base_d), 1);
        chk("t1_done_lat", 32'(done_cyc - last_hs), 1);
        acc_valid = 1'b0;

        // 2: arithmetic, ReLU, saturation, negative bias
        bias = 8'd3;
        pulse_start();
        send("t2_80", 80, 8, 0);
        send("t2_m160", -160, 0, 0);
        send("t2_4000", 4000, 127, 0);
        send("t2_m17", -17, 1, 0);
        bias = 8'hFE;
        send("t2_16", 16, 0, 1);
        send("t2_48", 48, 1, 1);
        send("t2_2064", 2064, 127, 1);
        send("t2_2080", 2080, 127, 1);
        wait_done("t2");
        tick();

        // 3: backpressure holds the output and stalls upstream
        bias      = 8'd3;
        out_ready = 1'b0;
        acc_data  = ACC_W'(80);
        acc_valid = 1'b1;
        pulse_start();
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        acc_data = ACC_W'(160);
        for (int i = 0; i < 5; i++) begin
            chk("t3_accrdy", 32'(acc_ready), 0);
            chk("t3_oval", 32'(out_valid), 1);
            chk("t3_odata", 32'(out_data), 8);
            chk("t3_och", 32'(out_ch), 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("t3_release_rdy", 32'(acc_ready), 1);
        tick();
        chk("t3_new_odata", 32'(out_data), 13);
        chk("t3_new_oval", 32'(out_valid), 1);
        wait_done("t3");
        tick();

        // 4: gappy input advances the pixel count only on transfers
        acc_valid = 1'b0;
        acc_data  = ACC_W'(80);
        pulse_start();
        tick();
        model = 0;
        for (int i = 0; i < 8; i++) begin
            acc_valid = ((i % 4) == 0) || ((i % 4) == 3);
            #1;
            tk = acc_valid && acc_ready;
            tick();
            if (tk) model++;
            chk($sformatf("t4_pix%0d", i), 32'(dut.pix_cnt), 32'(model));
            chk($sformatf("t4_cload%0d", i), 32'(c_load), 0);
        end
        acc_valid = 1'b1;
        #1;
        chk("t4_drain_rdy", 32'(acc_ready), 0);
        tick();
        chk("t4_cload", 32'(c_load), 1);
        chk("t4_cout", 32'(cout), 1);
        chk("t4_pix0", 32'(dut.pix_cnt), 0);
        wait_done("t4");
        tick();

        // 5: start while busy is ignored
        base_o    = oq_data.size();
        base_c    = cl_q.size();
        base_d    = n_done;
        acc_valid = 1'b0;
        pulse_start();
        tick();
        acc_valid = 1'b1;
        tick();
        tick();
        acc_valid = 1'b0;
        pulse_start();
        chk("t5_cout", 32'(cout), 0);
        chk("t5_pix", 32'(dut.pix_cnt), 2);
        chk("t5_cload", 32'(c_load), 0);
        chk("t5_busy", 32'(busy), 1);
        acc_valid = 1'b1;
        wait_done("t5");
        tick();
        tick();
        chk("t5_nout", 32'(oq_data.size() - base_o), 8);
        chk("t5_ncload", 32'(cl_q.size() - base_c), 2);
        chk("t5_ndone", 32'(n_done - base_d), 1);

        // 6: asynchronous reset mid-run
        acc_valid = 1'b1;
        out_ready = 1'b1;
        pulse_start();
        n = 0;
        while (!(out_valid && out_ch == 4'd1) && n < 50) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        tick();
        chk("t6_pre_och", 32'(out_ch), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_cload", 32'(c_load), 0);
        chk("t6_accrdy", 32'(acc_ready), 0);
        chk("t6_oval", 32'(out_valid), 0);
        chk("t6_cout", 32'(cout), 0);
        chk("t6_och", 32'(out_ch), 0);
        chk("t6_odata", 32'(out_data), 0);
        tick();
        rst       = 1'b1;
        acc_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        pulse_start();
        chk("t6_restart_cload", 32'(c_load), 1);
        chk("t6_restart_cout", 32'(cout), 0);
        chk("t6_restart_busy", 32'(busy), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_bias_relu.md
Name: conv_bias_relu

Overview:
Post-accumulation stage of the conv layer. Sequences output channels and drives the per-channel bias loader (c_load/cout). For each channel it takes a stream of MAC accumulator sums, rescales them, adds the channel bias, applies ReLU, saturates to int8 and streams the result downstream. It sits between the MAC array and the activation buffer, alongside the bias loader.

Parameters:
OC, 7, number of output channels minus 1 (channels 0..OC)
NPIX, 676, pixels per output channel (26x26 feature map)
ACC_W, 20, accumulator width in bits (signed two's complement)
SHIFT, 4, fractional bits removed from the accumulator before the bias add (arithmetic right shift)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a full layer pass (channels 0..OC)
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the last output of channel OC has been accepted downstream
c_load  out  1  to bias loader; one-cycle pulse requesting bias for cout
cout  out  4  to bias loader; current output channel index
bias  in  8  from bias loader; signed int8; valid from the cycle after c_load
acc_valid  in  1  upstream accumulator sum valid
acc_ready  out  1  this block accepts acc_data this cycle
acc_data  in  ACC_W  signed accumulator sum
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_data  out  8  signed int8 result, range 0..127
out_ch  out  4  channel index of out_data

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, c_load, acc_ready, out_valid = 0; cout, out_ch, out_data, pixel counter = 0.
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE: start=1 -> LOAD with cout=0. start in any other state is ignored.
- LOAD: c_load=1 for exactly one cycle; cout stable. Next state is RUN. bias is sampled as valid from the first RUN cycle and is held because c_load stays low.
- RUN: acc_ready = (!out_valid || out_ready) && (pix_cnt < NPIX). A transfer happens on acc_valid && acc_ready; pix_cnt increments on each transfer. When the transfer that makes pix_cnt reach NPIX occurs -> DRAIN.
- DRAIN: acc_ready=0. When out_valid=0, or out_valid && out_ready in this cycle: if cout==OC -> DONE; otherwise cout+1, pix_cnt=0 -> LOAD.
- DONE: done=1 for one cycle, cout=0 -> IDLE. busy=1 in LOAD/RUN/DRAIN/DONE.
- Datapath latency is 1 cycle: on an accepted transfer, out_data/out_ch/out_valid register on the same edge.
- out_valid stays high with out_data and out_ch stable until out_ready=1. It clears on out_ready unless a new transfer happens in the same cycle, in which case the output is overwritten with the new result and out_valid stays 1. There are no bubbles under full throughput.
- Arithmetic: s = (acc_data >>> SHIFT) + sign-extended bias, computed at ACC_W+1 bits with no overflow. ReLU: s<0 -> 0. Saturate: s>127 -> 127. Otherwise out_data=s[7:0].
- out_ch equals the cout at the time of transfer.
- Upstream must not present channel c+1 data before LOAD completes; acc_ready=0 outside RUN enforces this.
- Reset mid-pass: everything returns to the reset values and any in-flight output is dropped. A new start is needed.

Test Plan:
1. Full-pass sequencing: NPIX=4, OC=1, out_ready=1, acc_valid=1 constantly -> exactly 2 c_load pulses (cout=0, then 1), 8 outputs (out_ch 0,0,0,0,1,1,1,1), and done pulsed once in the cycle after the last output handshake; busy=0 after.
2. Arithmetic: bias=3, acc_data=80 -> out_data=8. acc_data=-160 -> 0 (ReLU). acc_data=4000 -> 127 (saturate). With bias=0xFE (-2), acc_data=16 -> 0 and acc_data=48 -> 1.
3. Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 -> acc_ready=0, and out_data/out_ch stay stable; release -> the next sample is accepted in the same cycle.
4. Gappy input: acc_valid toggled 1,0,0,1 -> pix_cnt advances only on transfers; the DRAIN transition happens only after the NPIX-th transfer.
5. Start ignored while busy: pulse start mid-RUN -> cout and pix_cnt unaffected, and done is still pulsed exactly once.
6. Async reset mid-RUN (rst low between clock edges) -> all outputs go to 0 immediately. After release, start -> c_load with cout=0.
